cd_host_regs: RTL

CD block host register interface on the SCU A-bus. Decodes CS2 accesses in the 0x189xxxx window, holds HIRQ/HIRQMASK and the CR1–CR4 command/response registers, and hands latched commands to the CD drive controller over a valid/ready handshake. Responses from the drive controller are loaded back into CR1–CR4 and raise HIRQ flags. It sits between the SCU A-bus slave port and the CD drive controller.

---
 rtl/cd_host_regs.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cd_host_regs.sv
// CD block host registers: A-bus decode, HIRQ/HIRQMASK, CR1-CR4, command FSM.
// Optional DTR sector FIFO enabled by defining CD_DTR_FIFO_EN.
module cd_host_regs #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [25:0] AA,
  input  logic        CS2_N,
  input  logic        RD_N,
  input  logic        WRL_N,
  input  logic        WRU_N,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        IRQ_N,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [63:0] CMD,
  input  logic        RSP_VALID,
  input  logic [63:0] RSP,
  input  logic [15:0] RSP_HIRQ,
  output logic        BUSY,
  input  logic        DATA_WR,
  input  logic [15:0] DATA_IN,
  output logic        DATA_FULL
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [1:0]  state;
  logic        idle_q;
  logic [15:0] hirq, hirq_nx, hirqmask;
  logic [15:0] cr [0:3];
  logic [15:0] cr_upd [0:3];
  logic [15:0] off, rd_val, dtr_head;
  logic [1:0]  lane, cr_idx;
  logic        strobes_idle, start, hit, rd_go, wr_go;
  logic        cr_hit, cr_wr, cmd_go, rsp, drq_set;

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] nw,
                                        input logic [1:0]  ln);
    merge = {ln[1] ? nw[15:8] : old[15:8],
             ln[0] ? nw[7:0]  : old[7:0]};
  endfunction

  assign strobes_idle = RD_N & WRL_N & WRU_N;
  assign start  = CE_R & idle_q & ~strobes_idle;
  assign hit    = ~CS2_N & (AA[25:16] == 10'h189);
  assign off    = AA[15:0];
  assign rd_go  = start & hit & ~RD_N;
  assign wr_go  = start & hit & RD_N;
  assign lane   = {~WRU_N, ~WRL_N};
  assign cr_hit = (off == 16'h0018) | (off == 16'h001C) |
                  (off == 16'h0020) | (off == 16'h0024);
  assign cr_idx = 2'(off[5:2] - 4'd6);
  assign cr_wr  = wr_go & cr_hit & (state == S_IDLE);
  assign cmd_go = cr_wr & (cr_idx == 2'd3);
  assign rsp    = CE_R & RSP_VALID;

  assign CMD_VALID = (state == S_PEND);
  assign BUSY      = (state != S_IDLE);

`ifdef CD_DTR_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push, pop;

  assign DATA_FULL = (cnt == (AW+1)'(FIFO_DEPTH));
  assign push      = CE_R & DATA_WR & ~DATA_FULL;
  assign pop       = rd_go & (off == 16'h0000) & (cnt != '0);
  assign drq_set   = push & (cnt == '0);
  assign dtr_head  = (cnt != '0) ? mem[rp] : 16'h0000;

  // Sector data storage
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= DATA_IN;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{DATA_WR, DATA_IN, 32'(FIFO_DEPTH)};
  assign DATA_FULL = 1'b0;
  assign drq_set   = 1'b0;
  assign dtr_head  = 16'h0000;
`endif

  // CR array with the current host write merged in
  always_comb begin
    for (int i = 0; i < 4; i++) cr_upd[i] = cr[i];
    if (cr_wr) cr_upd[cr_idx] = merge(cr[cr_idx], DI, lane);
  end

  // Next HIRQ: host clear first, then hardware sets win
  always_comb begin
    hirq_nx = hirq;
    if (wr_go && off == 16'h0008)
      hirq_nx = hirq & merge(16'hFFFF, DI, lane);
    if (cmd_go) hirq_nx[0] = 1'b0;
    if (rsp) hirq_nx = hirq_nx | RSP_HIRQ | 16'h0001;
    if (drq_set) hirq_nx[1] = 1'b1;
  end

  // Read data mux
  always_comb begin
    rd_val = 16'h0000;
    case (off)
      16'h0000: rd_val = dtr_head;
      16'h0008: rd_val = hirq;
      16'h000C: rd_val = hirqmask;
      16'h0018: rd_val = cr[0];
      16'h001C: rd_val = cr[1];
      16'h0020: rd_val = cr[2];
      16'h0024: rd_val = cr[3];
      default:  rd_val = 16'h0000;
    endcase
  end

  // Strobe edge detect, registers, read data and interrupt
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_q   <= 1'b1;
      hirq     <= 16'h0001;
      hirqmask <= 16'h0000;
      DO       <= 16'h0000;
      IRQ_N    <= 1'b1;
      CMD      <= 64'h0;
      cr[0]    <= 16'h0043;
      cr[1]    <= 16'h4442;
      cr[2]    <= 16'h4C4F;
      cr[3]    <= 16'h434B;
    end else if (CE_R) begin
      idle_q <= strobes_idle;
      hirq   <= hirq_nx;
      IRQ_N  <= ~|(hirq & hirqmask);
      if (rd_go) DO <= rd_val;
      if (wr_go && off == 16'h000C)
        hirqmask <= merge(hirqmask, DI, lane);
      if (cmd_go)
        CMD <= {cr_upd[0], cr_upd[1], cr_upd[2], cr_upd[3]};
      if (rsp) begin
        cr[0] <= RSP[63:48];
        cr[1] <= RSP[47:32];
        cr[2] <= RSP[31:16];
        cr[3] <= RSP[15:0];
      end else if (cr_wr) begin
        for (int i = 0; i < 4; i++) cr[i] <= cr_upd[i];
      end
    end
  end

  // Command FSM: IDLE -> CMD_PEND -> BUSY -> IDLE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else if (CE_R) begin
      case (state)
        S_IDLE:  if (cmd_go)    state <= S_PEND;
        S_PEND:  if (CMD_READY) state <= S_BUSY;
        S_BUSY:  if (RSP_VALID) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
